// File: rtl/rf_scoreboard.sv
// rf_scoreboard: integer register file with a pending-write scoreboard.
//
// Purpose:
//   Two architectural read ports and one debug read port; x0 is hard-wired to zero.
//   Optional same-cycle write-to-read bypass. A per-register pending bit is set when
//   an instruction issues with that destination and cleared by its writeback. An issue
//   to a still-pending destination is refused (WAW stall) unless the writeback for
//   that register lands in the same cycle.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   i_rs1_addr / i_rs2_addr      read addresses
//   o_rs1_data / o_rs2_data      combinational read data
//   o_rs1_ready / o_rs2_ready    operand usable this cycle
//   i_iss_en, i_iss_rd           issue request and its destination
//   o_iss_stall                  issue refused this cycle
//   i_wb_en, i_wb_rd, i_wb_data  writeback strobe, destination, data
//   i_dbg_addr, o_dbg_data       debug read (never bypassed)
//   o_pend_vec                   registered scoreboard bits, bit 0 always 0
module rf_scoreboard #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic            o_rs1_ready,
    output logic            o_rs2_ready,
    input  logic            i_iss_en,
    input  logic [AW-1:0]   i_iss_rd,
    output logic            o_iss_stall,
    input  logic            i_wb_en,
    input  logic [AW-1:0]   i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic [AW-1:0]   i_dbg_addr,
    output logic [XLEN-1:0] o_dbg_data,
    output logic [NREG-1:0] o_pend_vec
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_pend_d;

    logic w_wb_act;
    logic w_wb_hits_iss;
    logic w_stall;
    logic w_iss_act;

    assign w_wb_act      = i_wb_en && (i_wb_rd != '0);
    assign w_wb_hits_iss = i_wb_en && (i_wb_rd == i_iss_rd);
    // A writeback to the same register this cycle retires the older producer,
    // so the new issue may proceed.
    assign w_stall       = i_iss_en && (i_iss_rd != '0) && r_pend[i_iss_rd] && !w_wb_hits_iss;
    assign w_iss_act     = i_iss_en && !w_stall && (i_iss_rd != '0);

    // Register storage; index 0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_act) begin
            r_regs[i_wb_rd] <= i_wb_data;
        end
    end

    // Clear from writeback first, then set from issue, so set wins on a collision.
    always_comb begin
        w_pend_d = r_pend;
        if (w_wb_act) begin
            w_pend_d[i_wb_rd] = 1'b0;
        end
        if (w_iss_act) begin
            w_pend_d[i_iss_rd] = 1'b1;
        end
        w_pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_d;
        end
    end

    function automatic logic [XLEN-1:0] f_rd_data(input logic [AW-1:0] a);
        if (a == '0) begin
            return '0;
        end else if ((BYPASS != 0) && i_wb_en && (i_wb_rd == a)) begin
            return i_wb_data;
        end else begin
            return r_regs[a];
        end
    endfunction

    function automatic logic f_rd_ready(input logic [AW-1:0] a);
        if (a == '0) begin
            return 1'b1;
        end else if ((BYPASS != 0) && i_wb_en && (i_wb_rd == a)) begin
            return 1'b1;
        end else begin
            return !r_pend[a];
        end
    endfunction

    // Outputs are forced to their idle values while reset is held, so a
    // writeback strobe during reset cannot leak through the bypass path.
    always_comb begin
        o_rs1_data  = '0;
        o_rs2_data  = '0;
        o_rs1_ready = 1'b1;
        o_rs2_ready = 1'b1;
        o_iss_stall = 1'b0;
        o_dbg_data  = '0;
        if (rst_n) begin
            o_rs1_data  = f_rd_data(i_rs1_addr);
            o_rs2_data  = f_rd_data(i_rs2_addr);
            o_rs1_ready = f_rd_ready(i_rs1_addr);
            o_rs2_ready = f_rd_ready(i_rs2_addr);
            o_iss_stall = w_stall;
            o_dbg_data  = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];
        end
    end

    assign o_pend_vec = r_pend;

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed scenarios plus randomized traffic for rf_scoreboard,
// run against a bypassing instance and a non-bypassing instance sharing inputs.
module tb_rf_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   rs1_addr = '0, rs2_addr = '0, iss_rd = '0, wb_rd = '0, dbg_addr = '0;
    logic            iss_en = 1'b0, wb_en = 1'b0;
    logic [XLEN-1:0] wb_data = '0;

    logic [XLEN-1:0] b_rs1_data, b_rs2_data, b_dbg_data, n_rs1_data, n_rs2_data, n_dbg_data;
    logic            b_rs1_ready, b_rs2_ready, b_stall, n_rs1_ready, n_rs2_ready, n_stall;
    logic [NREG-1:0] b_pend, n_pend;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: architectural values and outstanding destinations.
    logic [XLEN-1:0] m_regs [NREG];
    bit              m_pend [NREG];

    always #5 clk = ~clk;

    rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
        .o_rs1_data(b_rs1_data), .o_rs2_data(b_rs2_data),
        .o_rs1_ready(b_rs1_ready), .o_rs2_ready(b_rs2_ready),
        .i_iss_en(iss_en), .i_iss_rd(iss_rd), .o_iss_stall(b_stall),
        .i_wb_en(wb_en), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .i_dbg_addr(dbg_addr), .o_dbg_data(b_dbg_data), .o_pend_vec(b_pend)
    );

    rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n),
        .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
        .o_rs1_data(n_rs1_data), .o_rs2_data(n_rs2_data),
        .o_rs1_ready(n_rs1_ready), .o_rs2_ready(n_rs2_ready),
        .i_iss_en(iss_en), .i_iss_rd(iss_rd), .o_iss_stall(n_stall),
        .i_wb_en(wb_en), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .i_dbg_addr(dbg_addr), .o_dbg_data(n_dbg_data), .o_pend_vec(n_pend)
    );

    // ---------------- reference model ----------------
    task automatic m_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    function automatic logic [XLEN-1:0] m_data(input logic [AW-1:0] a, input bit byp);
        if (!rst_n || a == 0) return '0;
        if (byp && wb_en && wb_rd == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic m_ready(input logic [AW-1:0] a, input bit byp);
        if (!rst_n || a == 0) return 1'b1;
        if (byp && wb_en && wb_rd == a) return 1'b1;
        return !m_pend[a];
    endfunction

    function automatic logic m_stall();
        if (!rst_n) return 1'b0;
        return iss_en && iss_rd != 0 && m_pend[iss_rd] && !(wb_en && wb_rd == iss_rd);
    endfunction

    function automatic logic [NREG-1:0] m_pend_vec();
        logic [NREG-1:0] v = '0;
        for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic m_clock();
        bit st = m_stall();
        if (wb_en && wb_rd != 0) begin
            m_regs[wb_rd] = wb_data;
            m_pend[wb_rd] = 1'b0;
        end
        if (iss_en && !st && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    endtask

    task automatic tick();
        m_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iss_en = 1'b0; wb_en = 1'b0; iss_rd = '0; wb_rd = '0; wb_data = '0;
        rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        m_reset();
        // Bypass path must stay quiet while reset is held.
        wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'hFFFF_0000; rs1_addr = 5'd4;
        iss_en = 1'b1; iss_rd = 5'd4;
        #3;
        n_vec++;
        if (b_rs1_data !== 32'h0 || b_rs1_ready !== 1'b1 || b_stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got data=%h ready=%b stall=%b, want 0/1/0",
                     b_rs1_data, b_rs1_ready, b_stall);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (b_pend !== '0 || n_pend !== '0) begin
            n_err++;
            $display("FAIL reset_pend: got %h/%h, want 0", b_pend, n_pend);
        end
        rs2_addr = 5'd17; dbg_addr = 5'd31; #1;
        n_vec++;
        if (b_rs2_data !== 32'h0 || b_dbg_data !== 32'h0 || b_rs2_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_regs: got rs2=%h dbg=%h rdy=%b, want 0/0/1",
                     b_rs2_data, b_dbg_data, b_rs2_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        rs1_addr = 5'd5; #1;
        n_vec++;
        if (b_rs1_data !== 32'hDEAD_BEEF || b_rs1_ready !== 1'b1 || n_rs1_data !== 32'hDEAD_BEEF)
        begin
            n_err++;
            $display("FAIL write_read: got %h/%h rdy=%b, want deadbeef rdy=1",
                     b_rs1_data, n_rs1_data, b_rs1_ready);
        end
    endtask

    task automatic test_x0();
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_1234; rs2_addr = 5'd0; #1;
        n_vec++;
        if (b_rs2_data !== 32'h0 || b_rs2_ready !== 1'b1) begin
            n_err++;
            $display("FAIL x0_bypass: got %h rdy=%b, want 0 rdy=1", b_rs2_data, b_rs2_ready);
        end
        tick();
        idle_inputs(); #1;
        n_vec++;
        if (b_rs2_data !== 32'h0 || b_pend[0] !== 1'b0 || b_dbg_data !== 32'h0) begin
            n_err++;
            $display("FAIL x0_write: got rs2=%h pend0=%b dbg=%h, want 0/0/0",
                     b_rs2_data, b_pend[0], b_dbg_data);
        end
        iss_en = 1'b1; iss_rd = 5'd0;
        tick();
        idle_inputs(); #1;
        n_vec++;
        if (b_pend !== '0) begin
            n_err++;
            $display("FAIL x0_issue: got pend=%h, want 0", b_pend);
        end
    endtask

    task automatic test_bypass();
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_0011;
        tick();
        wb_data = 32'hA5A5_A5A5; rs1_addr = 5'd7; dbg_addr = 5'd7; #1;
        n_vec++;
        if (b_rs1_data !== 32'hA5A5_A5A5 || n_rs1_data !== 32'h0000_0011
            || b_dbg_data !== 32'h0000_0011) begin
            n_err++;
            $display("FAIL bypass: got byp=%h nobyp=%h dbg=%h, want a5a5a5a5/00000011/00000011",
                     b_rs1_data, n_rs1_data, b_dbg_data);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        iss_en = 1'b1; iss_rd = 5'd3; #1;
        n_vec++;
        if (b_stall !== 1'b0) begin
            n_err++;
            $display("FAIL issue_first: got stall=%b, want 0", b_stall);
        end
        tick();
        rs1_addr = 5'd3; #1;
        n_vec++;
        if (b_pend[3] !== 1'b1 || b_rs1_ready !== 1'b0 || n_rs1_ready !== 1'b0
            || b_stall !== 1'b1 || n_stall !== 1'b1) begin
            n_err++;
            $display("FAIL issue_waw: got pend3=%b rdy=%b/%b stall=%b/%b, want 1 0/0 1/1",
                     b_pend[3], b_rs1_ready, n_rs1_ready, b_stall, n_stall);
        end
        tick();
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0033; #1;
        n_vec++;
        if (b_stall !== 1'b0 || n_stall !== 1'b0 || b_rs1_ready !== 1'b1
            || n_rs1_ready !== 1'b0 || b_rs1_data !== 32'h33) begin
            n_err++;
            $display("FAIL wb_unstall: got stall=%b/%b rdy=%b/%b data=%h, want 0/0 1/0 00000033",
                     b_stall, n_stall, b_rs1_ready, n_rs1_ready, b_rs1_data);
        end
        tick();
        idle_inputs(); dbg_addr = 5'd3; #1;
        n_vec++;
        if (b_pend[3] !== 1'b1 || b_dbg_data !== 32'h33) begin
            n_err++;
            $display("FAIL reissue: got pend3=%b dbg=%h, want 1/00000033", b_pend[3], b_dbg_data);
        end
    endtask

    task automatic test_same_cycle();
        iss_en = 1'b1; iss_rd = 5'd9; wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h9999_0009; #1;
        n_vec++;
        if (b_stall !== 1'b0) begin
            n_err++;
            $display("FAIL same_cycle_stall: got %b, want 0", b_stall);
        end
        tick();
        idle_inputs(); dbg_addr = 5'd9; #1;
        n_vec++;
        if (b_pend[9] !== 1'b1 || b_dbg_data !== 32'h9999_0009) begin
            n_err++;
            $display("FAIL same_cycle: got pend9=%b dbg=%h, want 1/99990009", b_pend[9], b_dbg_data);
        end
    endtask

    task automatic test_async_reset();
        wb_en = 1'b1; wb_rd = 5'd8; wb_data = 32'h55;
        tick();
        idle_inputs(); #1;
        n_vec++;
        if (b_pend !== 32'h0000_0208) begin
            n_err++;
            $display("FAIL pre_reset_pend: got %h, want 00000208", b_pend);
        end
        // Drop reset between clock edges with traffic on the buses.
        dbg_addr = 5'd8; wb_en = 1'b1; wb_rd = 5'd8; wb_data = 32'h77; rs1_addr = 5'd8;
        iss_en = 1'b1; iss_rd = 5'd3;
        #1;
        rst_n = 1'b0;
        m_reset();
        #1;
        n_vec++;
        if (b_pend !== '0 || n_pend !== '0 || b_dbg_data !== 32'h0 || b_rs1_data !== 32'h0
            || b_rs1_ready !== 1'b1 || b_stall !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got pend=%h dbg=%h data=%h rdy=%b stall=%b, want 0 0 0 1 0",
                     b_pend, b_dbg_data, b_rs1_data, b_rs1_ready, b_stall);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            // Mostly a small window of registers so hazards actually collide.
            rs1_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 5));
            rs2_addr = AW'($urandom_range(0, 5));
            dbg_addr = AW'($urandom_range(0, 5));
            iss_en   = $urandom_range(0, 1) == 1;
            iss_rd   = AW'($urandom_range(0, 5));
            wb_en    = $urandom_range(0, 2) == 0;
            wb_rd    = ($urandom_range(0, 1) == 0) ? iss_rd : AW'($urandom_range(0, 5));
            wb_data  = $urandom;
            #1;
            n_vec++;
            if ({b_rs1_data, b_rs2_data, b_rs1_ready, b_rs2_ready, b_stall, b_dbg_data, b_pend}
                !== {m_data(rs1_addr, 1), m_data(rs2_addr, 1), m_ready(rs1_addr, 1),
                     m_ready(rs2_addr, 1), m_stall(), m_data(dbg_addr, 0), m_pend_vec()}) begin
                n_err++;
                $display("FAIL random_byp c=%0d: got d=%h/%h r=%b%b s=%b dbg=%h p=%h, want d=%h/%h r=%b%b s=%b dbg=%h p=%h",
                         c, b_rs1_data, b_rs2_data, b_rs1_ready, b_rs2_ready, b_stall, b_dbg_data,
                         b_pend, m_data(rs1_addr, 1), m_data(rs2_addr, 1), m_ready(rs1_addr, 1),
                         m_ready(rs2_addr, 1), m_stall(), m_data(dbg_addr, 0), m_pend_vec());
            end
            n_vec++;
            if ({n_rs1_data, n_rs2_data, n_rs1_ready, n_rs2_ready, n_stall, n_pend}
                !== {m_data(rs1_addr, 0), m_data(rs2_addr, 0), m_ready(rs1_addr, 0),
                     m_ready(rs2_addr, 0), m_stall(), m_pend_vec()}) begin
                n_err++;
                $display("FAIL random_nobyp c=%0d: got d=%h/%h r=%b%b s=%b p=%h, want d=%h/%h r=%b%b s=%b p=%h",
                         c, n_rs1_data, n_rs2_data, n_rs1_ready, n_rs2_ready, n_stall, n_pend,
                         m_data(rs1_addr, 0), m_data(rs2_addr, 0), m_ready(rs1_addr, 0),
                         m_ready(rs2_addr, 0), m_stall(), m_pend_vec());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_scoreboard();
        test_same_cycle();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
